// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-stage blocks
// (access size codes and the load/store access FSM state encoding).
package mem_pkg;

    // Access size carried in memSelect[1:0]; code 3 is handled as WORD.
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_e;

    // Load/store access sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_e;

endpackage

// File: rtl/mem_access_be_gen.sv
// be_gen: byte-enable generation, store-lane replication and misalignment
// detection from the low address bits and the access size.
module be_gen
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic        misalign
);

    // Decode lanes for the requested size; unknown size code behaves as WORD.
    always_comb begin
        be         = 4'b1111;
        lane_wdata = wdata;
        misalign   = 1'b0;
        case (size)
            BYTE: begin
                be         = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
            end
            HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
                misalign   = addr_lo[0];
            end
            default: begin
                be         = 4'b1111;
                lane_wdata = wdata;
                misalign   = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: single-outstanding load/store sequencer between the pipeline
// memory stage and a request/ack data memory, with an ack timeout.
// Optional feature: define MEM_ALIGN_TRAP_EN to fault misaligned HALF/WORD
// accesses instead of issuing them.
module mem_access
    import mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memReq,
    input  logic        memWrite,
    input  logic [2:0]  memSelect,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ldData,
    output logic [3:0]  ldBe,
    output logic [2:0]  ldSelect,
    output logic        ldValid,
    output logic        fault
);

`ifdef MEM_ALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);

    state_e        state, next;
    logic [CW-1:0] cnt;

    logic [29:0]   addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic [2:0]    sel_q;

    logic [3:0]    be_c;
    logic [31:0]   lane_c;
    logic          misalign_c;

    be_gen u_be_gen (
        .addr_lo    (addr[1:0]),
        .size       (memSelect[1:0]),
        .wdata      (wdata),
        .be         (be_c),
        .lane_wdata (lane_c),
        .misalign   (misalign_c)
    );

    assign dmem_addr  = {addr_q, 2'b00};
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    // Next-state and control outputs; ack in the last allowed cycle beats timeout.
    always_comb begin
        next     = state;
        stall    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ldValid  = 1'b0;
        fault    = 1'b0;
        case (state)
            IDLE: begin
                if (memReq && !reset) begin
                    stall = 1'b1;
                    next  = (TRAP_EN && misalign_c) ? FAULT : BUSY;
                end
            end
            BUSY: begin
                stall    = 1'b1;
                dmem_req = 1'b1;
                dmem_we  = we_q;
                if (dmem_ack)            next = DONE;
                else if (cnt == TO_LAST) next = FAULT;
            end
            DONE: begin
                ldValid = 1'b1;
                next    = IDLE;
            end
            FAULT: begin
                fault = 1'b1;
                next  = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // BUSY cycle counter; held at zero outside BUSY so each access starts fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              cnt <= '0;
        else if (state != BUSY) cnt <= '0;
        else if (!dmem_ack)     cnt <= cnt + 1'b1;
    end

    // Request capture in IDLE and load-result latch on ack (stores leave it alone).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            ldData   <= '0;
            ldBe     <= '0;
            ldSelect <= '0;
        end else begin
            if (state == IDLE && memReq) begin
                addr_q  <= addr[31:2];
                be_q    <= be_c;
                wdata_q <= lane_c;
                we_q    <= memWrite;
                sel_q   <= memSelect;
            end
            if (state == BUSY && dmem_ack && !we_q) begin
                ldData   <= dmem_rdata;
                ldBe     <= be_q;
                ldSelect <= sel_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed scoreboard bench for mem_access.
module tb_mem_access;

    localparam int TO = 16;

`ifdef MEM_ALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        memReq, memWrite;
    logic [2:0]  memSelect;
    logic [31:0] addr, wdata;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] ldData;
    logic [3:0]  ldBe;
    logic [2:0]  ldSelect;
    logic        ldValid, fault;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          is_fault;
        logic [31:0] data;
        logic [3:0]  be;
        logic [2:0]  sel;
        int          busy;
    } exp_t;

    exp_t sbq[$];

    logic [31:0] m_data = '0;
    logic [3:0]  m_be   = '0;
    logic [2:0]  m_sel  = '0;

    mem_access #(.ACK_TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .memReq     (memReq),
        .memWrite   (memWrite),
        .memSelect  (memSelect),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .ldData     (ldData),
        .ldBe       (ldBe),
        .ldSelect   (ldSelect),
        .ldValid    (ldValid),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'd0:    return 4'b0001 << lo;
            2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ref_wd(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic bit ref_mis(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stall"},    32'(stall),    32'd0);
        chk({tag, "_dmem_req"}, 32'(dmem_req), 32'd0);
        chk({tag, "_dmem_we"},  32'(dmem_we),  32'd0);
        chk({tag, "_addr"},     dmem_addr,     32'd0);
        chk({tag, "_be"},       32'(dmem_be),  32'd0);
        chk({tag, "_wdata"},    dmem_wdata,    32'd0);
        chk({tag, "_ldData"},   ldData,        32'd0);
        chk({tag, "_ldBe"},     32'(ldBe),     32'd0);
        chk({tag, "_ldSelect"}, 32'(ldSelect), 32'd0);
        chk({tag, "_ldValid"},  32'(ldValid),  32'd0);
        chk({tag, "_fault"},    32'(fault),    32'd0);
    endtask

    // ack_at: BUSY cycle (1-based) in which ack is returned; 0 = never.
    task automatic access(input bit we, input logic [2:0] sel, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
        exp_t        e, got;
        int          busy, lat;
        bit          done;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        bit          trap;

        ebe  = ref_be(sel[1:0], a[1:0]);
        ewd  = ref_wd(sel[1:0], wd);
        trap = TRAP && ref_mis(sel[1:0], a[1:0]);
        e.is_fault = trap || ack_at == 0 || ack_at > TO;
        e.busy     = trap ? 0 : (e.is_fault ? TO : ack_at);
        if (!we && !e.is_fault) begin
            m_data = rd;
            m_be   = ebe;
            m_sel  = sel;
        end
        e.data = m_data;
        e.be   = m_be;
        e.sel  = m_sel;
        sbq.push_back(e);

        @(negedge clk);
        memReq = 1'b1; memWrite = we; memSelect = sel; addr = a; wdata = wd;
        #1 chk("stall_on_req", 32'(stall), 32'd1);
        @(negedge clk);
        memReq = 1'b0; memWrite = 1'b0; memSelect = '0; addr = '0; wdata = '0;

        busy = 0; lat = 1; done = 1'b0;
        for (int c = 0; c < TO + 4; c++) begin
            if (ldValid || fault) begin
                done = 1'b1;
                break;
            end
            if (dmem_req) begin
                busy++;
                chk("busy_stall", 32'(stall), 32'd1);
                chk("busy_addr", dmem_addr, {a[31:2], 2'b00});
                chk("busy_be", 32'(dmem_be), 32'(ebe));
                chk("busy_wdata", dmem_wdata, ewd);
                chk("busy_we", 32'(dmem_we), 32'(we));
                if (busy == ack_at) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rd;
                end
            end
            @(negedge clk);
            dmem_ack   = 1'b0;
            dmem_rdata = 32'hDEAD_BEEF;
            lat++;
        end

        chk("completion_seen", 32'(done), 32'd1);
        got = sbq.pop_front();
        chk("fault", 32'(fault), 32'(got.is_fault));
        chk("ldValid", 32'(ldValid), 32'(!got.is_fault));
        chk("ldData", ldData, got.data);
        chk("ldBe", 32'(ldBe), 32'(got.be));
        chk("ldSelect", 32'(ldSelect), 32'(got.sel));
        chk("busy_cycles", 32'(busy), 32'(got.busy));
        chk("latency", 32'(lat), 32'(got.busy + 1));
        chk("end_stall", 32'(stall), 32'd0);
        chk("end_dmem_req", 32'(dmem_req), 32'd0);

        @(negedge clk);
        chk("pulse_ldValid", 32'(ldValid), 32'd0);
        chk("pulse_fault", 32'(fault), 32'd0);
        chk("idle_dmem_req", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        reset = 1'b1; memReq = 1'b0; memWrite = 1'b0; memSelect = '0;
        addr = '0; wdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        // Signed byte load from top lane, ack in first BUSY cycle.
        access(1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'hAB00_0000, 1);
        // Halfword store to upper half.
        access(1'b1, 3'b001, 32'h0000_2002, 32'h0000_1234, 32'h5555_5555, 1);
        // Word load after 5 wait cycles.
        access(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 6);
        // No ack: timeout fault.
        access(1'b0, 3'b010, 32'h0000_4004, 32'h0, 32'h0, 0);
        // Ack on the last allowed cycle completes normally.
        access(1'b0, 3'b001, 32'h0000_4008, 32'h0, 32'h1357_9BDF, TO);
        // Misaligned word.
        access(1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h2468_ACE0, 1);
        // Misaligned halfword store.
        access(1'b1, 3'b001, 32'h0000_7001, 32'h0000_BEEF, 32'h0, 2);
        // Byte store into lane 1.
        access(1'b1, 3'b000, 32'h0000_5001, 32'hFFFF_FFCD, 32'h0, 1);
        // Signed halfword load from upper half.
        access(1'b0, 3'b101, 32'h0000_6002, 32'h0, 32'h8001_7FFF, 3);
        // Size code 3 behaves as word.
        access(1'b1, 3'b011, 32'h0000_9000, 32'h89AB_CDEF, 32'h0, 1);

        // Reset in the middle of BUSY.
        @(negedge clk);
        memReq = 1'b1; memWrite = 1'b0; memSelect = 3'b010; addr = 32'h0000_8000;
        @(negedge clk);
        memReq = 1'b0; memSelect = '0; addr = '0;
        chk("pre_reset_busy", 32'(dmem_req), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1 chk_zero("midreset");
        m_data = '0; m_be = '0; m_sel = '0;
        @(negedge clk);
        reset = 1'b0;
        access(1'b0, 3'b010, 32'h0000_8004, 32'h0, 32'h0F0F_1234, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
